hypot_seq_ctrl: RTL

Multi-cycle sequencer that computes floor(sqrt(x² + y²)) for two 8-bit unsigned operands by time-sharing one 8-bit squarer and a shift-subtract root stage. It sits between the Tiny Tapeout pin wrapper (tt_um_addon: ui_in = x, uio_in = y, uo_out = result) and the arithmetic, replacing a flat combinational path with a start/busy/done handshake. Latency is fixed at 12 cycles per operation.

---
 rtl/hypot_pkg.sv | 17 +
 rtl/hypot_seq_ctrl_if.sv | 23 ++
 rtl/hypot_sq8.sv | 11 +
 rtl/hypot_seq_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hypot_pkg.sv
// rtl/hypot_pkg.sv - shared state encoding and widths for the hypotenuse sequencer
package hypot_pkg;

    localparam int X_W        = 8;
    localparam int SUM_W      = 17;
    localparam int ROOT_W     = 9;
    localparam int ROOT_ITERS = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ_X = 3'd1,
        SQ_Y = 3'd2,
        ROOT = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/hypot_seq_ctrl_if.sv
// rtl/hypot_seq_ctrl_if.sv - start/busy/done handshake and operand/result bundle
interface hypot_seq_ctrl_if;
    import hypot_pkg::*;

    logic              start;
    logic [X_W-1:0]    x;
    logic [X_W-1:0]    y;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] result;
    logic              ovf;

    modport master (
        output start, x, y,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, x, y,
        output busy, done, result, ovf
    );

endinterface

// File: rtl/hypot_sq8.sv
// rtl/hypot_sq8.sv - combinational 8-bit to 16-bit squarer
module hypot_sq8
    import hypot_pkg::*;
(
    input  logic [X_W-1:0]   i_a,
    output logic [2*X_W-1:0] o_sq
);

    assign o_sq = {{X_W{1'b0}}, i_a} * {{X_W{1'b0}}, i_a};

endmodule

// File: rtl/hypot_seq_ctrl.sv
// rtl/hypot_seq_ctrl.sv - multi-cycle floor(sqrt(x^2 + y^2)) with one shared squarer
module hypot_seq_ctrl
    import hypot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    hypot_seq_ctrl_if.slave   bus
);

    state_t              r_state;
    state_t              w_next;
    logic [X_W-1:0]      r_x;
    logic [X_W-1:0]      r_y;
    logic [SUM_W-1:0]    r_acc;
    logic [9:0]          r_rem;
    logic [ROOT_W-1:0]   r_root;
    logic [3:0]          r_iter;
    logic                r_busy;
    logic                r_done;
    logic [ROOT_W-1:0]   r_result;
    logic                r_ovf;

    logic [X_W-1:0]      w_sq_in;
    logic [2*X_W-1:0]    w_sq;
    logic [SUM_W:0]      w_acc_pad;
    logic [1:0]          w_pair;
    logic [12:0]         w_minuend;
    logic [12:0]         w_subtrahend;
    logic [12:0]         w_trial;
    logic                w_ge;
    logic [9:0]          w_rem_next;
    logic [ROOT_W-1:0]   w_root_next;

    // The single squarer sees x in SQ_X and y in SQ_Y.
    assign w_sq_in = (r_state == SQ_Y) ? r_y : r_x;

    hypot_sq8 u_sq (
        .i_a  (w_sq_in),
        .o_sq (w_sq)
    );

    // Pad the 17-bit sum to an even width so every iteration consumes a bit pair.
    assign w_acc_pad    = {1'b0, r_acc};
    assign w_pair       = 2'(w_acc_pad >> {r_iter, 1'b0});
    assign w_minuend    = {1'b0, r_rem, w_pair};
    assign w_subtrahend = {2'b00, r_root, 2'b01};
    assign w_trial      = w_minuend - w_subtrahend;
    assign w_ge         = ~w_trial[12];
    assign w_rem_next   = w_ge ? 10'(w_trial) : 10'(w_minuend);
    assign w_root_next  = {r_root[ROOT_W-2:0], w_ge};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SQ_X;
            SQ_X:    w_next = SQ_Y;
            SQ_Y:    w_next = ROOT;
            ROOT:    if (r_iter == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand latch, accumulate squares, then one root bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_iter   <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_x    <= bus.x;
                        r_y    <= bus.y;
                        r_acc  <= '0;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_iter <= 4'(ROOT_ITERS - 1);
                    end
                end
                SQ_X: r_acc <= SUM_W'(w_sq);
                SQ_Y: r_acc <= r_acc + SUM_W'(w_sq);
                ROOT: begin
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    if (r_iter == 4'd0) begin
                        r_result <= w_root_next;
                        r_ovf    <= w_root_next[ROOT_W-1];
                    end else begin
                        r_iter <= r_iter - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;

endmodule
